// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches and buffers
// returned instructions with their PCs in a small FIFO toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        br_taken_i,
  input  logic [31:0] br_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misaligned_o,
  output logic [31:0] misaligned_addr_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic {
    ST_FETCH,
    ST_HALT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      pc;
  logic [31:0]      req_pc;
  logic             outst;
  logic             drop;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      held_instr;
  logic [31:0]      held_pc;

  logic             req;
  logic             grant;
  logic             redirect;
  logic             bad_target;
  logic             push;
  logic             pop;
  logic             fifo_valid;
  logic [CNT_W:0]   occupancy;

  assign redirect   = br_taken_i && (state == ST_FETCH);
  assign bad_target = redirect && (br_addr_i[1:0] != 2'b00);
  assign fifo_valid = (count != '0);

  // The outstanding response always claims a slot, even when it returns this
  // cycle, so a new grant can never overrun the buffer.
  assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, outst};

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    if (state == ST_FETCH) begin
      req = rst_ni && (!outst || imem_rvalid_i) && (occupancy < DEPTH_C) && !br_taken_i;
      if (bad_target) state_nxt = ST_HALT;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc;
  assign grant       = req && imem_gnt_i;

  // A response in the redirect cycle is wrong-path and never reaches the FIFO.
  assign push = imem_rvalid_i && outst && !drop && (state == ST_FETCH) && !br_taken_i;

  assign instr_valid_o = fifo_valid && !br_taken_i;
  assign pop           = instr_valid_o && instr_ready_i;

  assign instr_o    = fifo_valid ? fifo_instr[rd_ptr] : held_instr;
  assign instr_pc_o = fifo_valid ? fifo_pc[rd_ptr]    : held_pc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc     <= RESET_ADDR;
      req_pc <= RESET_ADDR;
      outst  <= 1'b0;
      drop   <= 1'b0;
    end else begin
      if (redirect && !bad_target) begin
        pc <= br_addr_i;
      end else if (grant) begin
        pc <= pc + 32'd4;
      end
      if (grant) req_pc <= pc;
      outst <= grant || (outst && !imem_rvalid_i);
      if (redirect) begin
        drop <= (outst && !imem_rvalid_i) || grant;
      end else if (outst && imem_rvalid_i) begin
        drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misaligned_o      <= 1'b0;
      misaligned_addr_o <= 32'h0;
    end else if (bad_target) begin
      misaligned_o      <= 1'b1;
      misaligned_addr_o <= br_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata_i;
      fifo_pc[wr_ptr]    <= req_pc;
    end
  end

  // Last visible head, so the outputs hold steady once the FIFO drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_instr <= 32'h0;
      held_pc    <= 32'h0;
    end else if (fifo_valid) begin
      held_instr <= fifo_instr[rd_ptr];
      held_pc    <= fifo_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for fetch/backpressure/redirects,
// plus hand sequences for the misaligned trap and PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        gnt, rvalid, ready;
  logic [31:0] rdata;
  logic        req, valid, mis;
  logic [31:0] addr, instr, ipc, mis_addr;

  logic        gnt2, rvalid2;
  logic [31:0] rdata2;
  logic        req2, valid2, mis2;
  logic [31:0] addr2, instr2, ipc2, mis_addr2;
  logic        br2 = 1'b0;
  logic [31:0] br_addr2 = 32'h0;
  logic        ready2 = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .br_taken_i(br_taken), .br_addr_i(br_addr),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc),
    .instr_ready_i(ready), .misaligned_o(mis), .misaligned_addr_o(mis_addr)
  );

  fetch_unit #(.RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .br_taken_i(br2), .br_addr_i(br_addr2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2),
    .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .instr_valid_o(valid2), .instr_o(instr2), .instr_pc_o(ipc2),
    .instr_ready_i(ready2), .misaligned_o(mis2), .misaligned_addr_o(mis_addr2)
  );

  typedef struct {
    logic        br;
    logic [31:0] baddr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] iins;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'h1300_0000 | a;
  endfunction

  function automatic vec_t mkv(input logic br, input logic [31:0] baddr,
                               input logic g, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic rq, input logic [31:0] ad,
                               input logic v, input logic [31:0] pc, input logic [31:0] ins);
    vec_t t;
    t.br = br; t.baddr = baddr; t.gnt = g; t.rv = rv; t.rdata = rd; t.rdy = rdy;
    t.req = rq; t.addr = ad; t.vld = v; t.ipc = pc; t.iins = ins;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic [31:0] ba, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    @(posedge clk);
    #1;
    br_taken = b; br_addr = ba; gnt = g; rvalid = rv; rdata = rd; ready = rdy;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},      {31'h0, req},   32'h0);
    chk({tag, "_addr"},     addr,           32'h0);
    chk({tag, "_valid"},    {31'h0, valid}, 32'h0);
    chk({tag, "_instr"},    instr,          32'h0);
    chk({tag, "_ipc"},      ipc,            32'h0);
    chk({tag, "_mis"},      {31'h0, mis},   32'h0);
    chk({tag, "_mis_addr"}, mis_addr,       32'h0);
    chk({tag, "_addr2"},    addr2,          32'hFFFF_FFF8);
    chk({tag, "_req2"},     {31'h0, req2},  32'h0);
  endtask

  initial begin
    // br, baddr, gnt, rv, rdata, rdy | req, addr, vld, head pc, head instr
    vecs[0]  = mkv(0, 0,      1, 0, 0,            1, 1, 32'h000, 0, 32'h000, 32'h0);
    vecs[1]  = mkv(0, 0,      1, 1, dat(32'h000), 1, 1, 32'h004, 0, 32'h000, 32'h0);
    vecs[2]  = mkv(0, 0,      1, 1, dat(32'h004), 1, 0, 32'h008, 1, 32'h000, dat(32'h000));
    vecs[3]  = mkv(0, 0,      1, 0, 0,            1, 1, 32'h008, 1, 32'h004, dat(32'h004));
    vecs[4]  = mkv(0, 0,      1, 1, dat(32'h008), 1, 1, 32'h00C, 0, 32'h004, dat(32'h004));
    vecs[5]  = mkv(0, 0,      1, 1, dat(32'h00C), 0, 0, 32'h010, 1, 32'h008, dat(32'h008));
    vecs[6]  = mkv(0, 0,      1, 0, 0,            0, 0, 32'h010, 1, 32'h008, dat(32'h008));
    vecs[7]  = mkv(0, 0,      1, 0, 0,            0, 0, 32'h010, 1, 32'h008, dat(32'h008));
    vecs[8]  = mkv(0, 0,      1, 0, 0,            1, 0, 32'h010, 1, 32'h008, dat(32'h008));
    vecs[9]  = mkv(0, 0,      1, 0, 0,            0, 1, 32'h010, 1, 32'h00C, dat(32'h00C));
    vecs[10] = mkv(1, 32'h100,1, 0, 0,            1, 0, 32'h014, 0, 32'h00C, dat(32'h00C));
    vecs[11] = mkv(0, 0,      1, 1, dat(32'h010), 1, 1, 32'h100, 0, 32'h00C, dat(32'h00C));
    vecs[12] = mkv(0, 0,      0, 1, dat(32'h100), 1, 1, 32'h104, 0, 32'h00C, dat(32'h00C));
    vecs[13] = mkv(0, 0,      0, 0, 0,            1, 1, 32'h104, 1, 32'h100, dat(32'h100));
    vecs[14] = mkv(0, 0,      1, 0, 0,            1, 1, 32'h104, 0, 32'h100, dat(32'h100));
    vecs[15] = mkv(1, 32'h200,1, 1, dat(32'h104), 1, 0, 32'h108, 0, 32'h100, dat(32'h100));
    vecs[16] = mkv(0, 0,      1, 0, 0,            1, 1, 32'h200, 0, 32'h100, dat(32'h100));
    vecs[17] = mkv(0, 0,      0, 1, dat(32'h200), 1, 1, 32'h204, 0, 32'h100, dat(32'h100));
    vecs[18] = mkv(0, 0,      0, 0, 0,            1, 1, 32'h204, 1, 32'h200, dat(32'h200));
    vecs[19] = mkv(0, 0,      0, 0, 0,            1, 1, 32'h204, 0, 32'h200, dat(32'h200));

    rst_n = 1'b0;
    br_taken = 0; br_addr = 0; gnt = 0; rvalid = 0; rdata = 0; ready = 0;
    gnt2 = 0; rvalid2 = 0; rdata2 = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].br, vecs[i].baddr, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   {31'h0, req},   {31'h0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),  addr,           vecs[i].addr);
      chk($sformatf("v%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].vld});
      chk($sformatf("v%0d_ipc", i),   ipc,            vecs[i].ipc);
      chk($sformatf("v%0d_instr", i), instr,          vecs[i].iins);
      chk($sformatf("v%0d_mis", i),   {31'h0, mis},   32'h0);
    end

    // Misaligned redirect while a fetch is outstanding, then HALT behaviour.
    drive(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    chk("m_req_pre", {31'h0, req}, 32'h1);
    chk("m_addr_pre", addr, 32'h204);
    drive(1, 32'h102, 1, 0, 0, 1);
    @(negedge clk);
    chk("m_req_br", {31'h0, req}, 32'h0);
    chk("m_valid_br", {31'h0, valid}, 32'h0);
    drive(0, 0, 1, 1, 32'hDEAD_BEEF, 1);
    @(negedge clk);
    chk("m_flag", {31'h0, mis}, 32'h1);
    chk("m_flag_addr", mis_addr, 32'h102);
    chk("m_req_halt", {31'h0, req}, 32'h0);
    drive(1, 32'h300, 1, 0, 0, 1);
    @(negedge clk);
    chk("m_req_br2", {31'h0, req}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("h%0d_req", k), {31'h0, req}, 32'h0);
      chk($sformatf("h%0d_valid", k), {31'h0, valid}, 32'h0);
      chk($sformatf("h%0d_mis", k), {31'h0, mis}, 32'h1);
      chk($sformatf("h%0d_mis_addr", k), mis_addr, 32'h102);
    end

    // Asynchronous reset mid-operation clears the trap.
    @(posedge clk);
    #1;
    gnt = 0; rvalid = 0; br_taken = 0;
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'h0, req}, 32'h1);
    chk("post_rst_addr", addr, 32'h0);

    // PC wrap-around from RESET_ADDR = 0xFFFF_FFF8.
    @(posedge clk); #1; gnt2 = 1; rvalid2 = 0;
    @(negedge clk);
    chk("w0_req", {31'h0, req2}, 32'h1);
    chk("w0_addr", addr2, 32'hFFFF_FFF8);
    @(posedge clk); #1; gnt2 = 1; rvalid2 = 1; rdata2 = 32'hE100_0001;
    @(negedge clk);
    chk("w1_req", {31'h0, req2}, 32'h1);
    chk("w1_addr", addr2, 32'hFFFF_FFFC);
    @(posedge clk); #1; gnt2 = 1; rvalid2 = 1; rdata2 = 32'hE200_0002;
    @(negedge clk);
    chk("w2_req", {31'h0, req2}, 32'h0);
    chk("w2_addr", addr2, 32'h0000_0000);
    chk("w2_valid", {31'h0, valid2}, 32'h1);
    chk("w2_ipc", ipc2, 32'hFFFF_FFF8);
    chk("w2_instr", instr2, 32'hE100_0001);
    @(posedge clk); #1; gnt2 = 1; rvalid2 = 0;
    @(negedge clk);
    chk("w3_req", {31'h0, req2}, 32'h1);
    chk("w3_addr", addr2, 32'h0000_0000);
    chk("w3_ipc", ipc2, 32'hFFFF_FFFC);
    chk("w3_instr", instr2, 32'hE200_0002);
    @(posedge clk); #1; gnt2 = 1; rvalid2 = 1; rdata2 = 32'hE300_0003;
    @(negedge clk);
    chk("w4_addr", addr2, 32'h0000_0004);
    chk("w4_valid", {31'h0, valid2}, 32'h0);
    @(posedge clk); #1; gnt2 = 0; rvalid2 = 1; rdata2 = 32'hE400_0004;
    @(negedge clk);
    chk("w5_req", {31'h0, req2}, 32'h0);
    chk("w5_valid", {31'h0, valid2}, 32'h1);
    chk("w5_ipc", ipc2, 32'h0000_0000);
    chk("w5_instr", instr2, 32'hE300_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
